// File: rtl/cell_stack_pkg.sv
// -----------------------------------------------------------------------------
// cell_stack_pkg
// Shared definitions for the cell_stack data/return stack:
//   - command op-code constants (CMD_OP_W bits wide)
//   - controller state encoding
// -----------------------------------------------------------------------------
package cell_stack_pkg;

    localparam int CMD_OP_W = 3;

    localparam logic [CMD_OP_W-1:0] OP_NOP     = 3'd0;
    localparam logic [CMD_OP_W-1:0] OP_PUSH    = 3'd1;
    localparam logic [CMD_OP_W-1:0] OP_POP     = 3'd2;
    localparam logic [CMD_OP_W-1:0] OP_REPLACE = 3'd3;
    localparam logic [CMD_OP_W-1:0] OP_SWAP    = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_POP_WAIT  = 2'd1,
        ST_SWAP_WAIT = 2'd2
    } state_t;

endpackage : cell_stack_pkg

// File: rtl/cell_stack_ram.sv
// -----------------------------------------------------------------------------
// cell_stack_ram
// Single-port synchronous RAM holding the stack entries below TOS.
// Read data is registered: dout reflects mem[addr] one cycle after addr.
// Not reset; contents are don't-care after reset.
// Ports:
//   clk       in   clock
//   addr      in   word address (DEPTH_LOG2 bits)
//   din       in   write data
//   write_en  in   write strobe
//   dout      out  registered read data
// -----------------------------------------------------------------------------
module cell_stack_ram
    import cell_stack_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [DATA_W-1:0]     din,
    input  logic                  write_en,
    output logic [DATA_W-1:0]     dout
);

    logic [DATA_W-1:0] mem [0:(1<<DEPTH_LOG2)-1];

    always_ff @(posedge clk) begin
        if (write_en) begin
            mem[addr] <= din;
        end
        dout <= mem[addr];
    end

endmodule : cell_stack_ram

// File: rtl/cell_stack.sv
// -----------------------------------------------------------------------------
// cell_stack
// Parametrised hardware stack. TOS lives in a register, entries below it in
// cell_stack_ram (entry k at ram[k]; for depth d, RAM holds entries 0..d-2).
// Commands use a valid/ready handshake; POP with depth>1 and SWAP take two
// cycles because the RAM read is registered.
// Optional feature: define CELL_STACK_SWAP_EN to enable op 4 (SWAP);
// otherwise op 4 is an accepted no-op.
// Ports:
//   CLK        in   clock, posedge
//   resetn     in   async active-low reset
//   cmd_valid  in   command request
//   cmd_op     in   0 NOP, 1 PUSH, 2 POP, 3 REPLACE, 4 SWAP, 5-7 reserved
//   cmd_wdata  in   data for PUSH/REPLACE
//   cmd_ready  out  high only in IDLE
//   tos        out  registered top of stack
//   depth      out  cells held, 0..2**DEPTH_LOG2
//   empty      out  depth==0
//   full       out  depth==capacity
//   overflow   out  sticky: PUSH while full
//   underflow  out  sticky: POP/REPLACE/SWAP with too few cells
//   err_clr    in   clears both sticky flags (a same-cycle set wins)
// -----------------------------------------------------------------------------
module cell_stack
    import cell_stack_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  CLK,
    input  logic                  resetn,
    input  logic                  cmd_valid,
    input  logic [CMD_OP_W-1:0]   cmd_op,
    input  logic [DATA_W-1:0]     cmd_wdata,
    output logic                  cmd_ready,
    output logic [DATA_W-1:0]     tos,
    output logic [DEPTH_LOG2:0]   depth,
    output logic                  empty,
    output logic                  full,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  err_clr
);

    localparam logic [DEPTH_LOG2:0] ZERO_V = '0;
    localparam logic [DEPTH_LOG2:0] ONE_V  = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2:0] TWO_V  = ONE_V << 1;
    localparam logic [DEPTH_LOG2:0] CAP_V  = {1'b1, {DEPTH_LOG2{1'b0}}};

    state_t                  state_q, state_d;
    logic [DEPTH_LOG2:0]     depth_q, depth_d;
    logic [DATA_W-1:0]       tos_q, tos_d;
    logic                    overflow_q, overflow_d;
    logic                    underflow_q, underflow_d;
    logic                    ovf_set, unf_set;

    logic [DEPTH_LOG2-1:0]   ram_addr;
    logic [DATA_W-1:0]       ram_din;
    logic [DATA_W-1:0]       ram_dout;
    logic                    ram_we;

    cell_stack_ram #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clk      (CLK),
        .addr     (ram_addr),
        .din      (ram_din),
        .write_en (ram_we),
        .dout     (ram_dout)
    );

    always_comb begin
        state_d   = state_q;
        depth_d   = depth_q;
        tos_d     = tos_q;
        // Next-on-stack address: used by the POP/SWAP read and the SWAP write-back.
        ram_addr  = DEPTH_LOG2'(depth_q - TWO_V);
        ram_din   = tos_q;
        ram_we    = 1'b0;
        ovf_set   = 1'b0;
        unf_set   = 1'b0;
        cmd_ready = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_PUSH: begin
                            if (depth_q == CAP_V) begin
                                ovf_set = 1'b1;
                            end else begin
                                // Spill old TOS into RAM only if there was one.
                                ram_addr = DEPTH_LOG2'(depth_q - ONE_V);
                                ram_we   = (depth_q != ZERO_V);
                                tos_d    = cmd_wdata;
                                depth_d  = depth_q + ONE_V;
                            end
                        end
                        OP_POP: begin
                            if (depth_q == ZERO_V) begin
                                unf_set = 1'b1;
                            end else if (depth_q == ONE_V) begin
                                tos_d   = '0;
                                depth_d = ZERO_V;
                            end else begin
                                state_d = ST_POP_WAIT;
                            end
                        end
                        OP_REPLACE: begin
                            if (depth_q == ZERO_V) begin
                                unf_set = 1'b1;
                            end else begin
                                tos_d = cmd_wdata;
                            end
                        end
`ifdef CELL_STACK_SWAP_EN
                        OP_SWAP: begin
                            if (depth_q < TWO_V) begin
                                unf_set = 1'b1;
                            end else begin
                                state_d = ST_SWAP_WAIT;
                            end
                        end
`endif
                        default: ;
                    endcase
                end
            end
            ST_POP_WAIT: begin
                tos_d   = ram_dout;
                depth_d = depth_q - ONE_V;
                state_d = ST_IDLE;
            end
`ifdef CELL_STACK_SWAP_EN
            ST_SWAP_WAIT: begin
                // Old TOS goes to the slot just read; read data becomes TOS.
                ram_we  = 1'b1;
                tos_d   = ram_dout;
                state_d = ST_IDLE;
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        overflow_d  = ovf_set | (overflow_q  & ~err_clr);
        underflow_d = unf_set | (underflow_q & ~err_clr);
    end

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            depth_q     <= ZERO_V;
            tos_q       <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            depth_q     <= depth_d;
            tos_q       <= tos_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign tos       = tos_q;
    assign depth     = depth_q;
    assign empty     = (depth_q == ZERO_V);
    assign full      = (depth_q == CAP_V);
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule : cell_stack

// File: tb/tb_cell_stack.sv
// -----------------------------------------------------------------------------
// tb_cell_stack
// Self-checking bench for cell_stack (DEPTH_LOG2=2, capacity 4).
// Reference model: a queue of cells plus two sticky flags.
// Honours CELL_STACK_SWAP_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_cell_stack;
    import cell_stack_pkg::*;

    localparam int DW  = 32;
    localparam int DL2 = 2;
    localparam int CAP = 1 << DL2;

    logic           CLK = 1'b0;
    logic           resetn = 1'b0;
    logic           cmd_valid = 1'b0;
    logic [2:0]     cmd_op = 3'd0;
    logic [DW-1:0]  cmd_wdata = '0;
    logic           err_clr = 1'b0;
    logic           cmd_ready;
    logic [DW-1:0]  tos;
    logic [DL2:0]   depth;
    logic           empty, full, overflow, underflow;

    cell_stack #(.DATA_W(DW), .DEPTH_LOG2(DL2)) dut (
        .CLK       (CLK),
        .resetn    (resetn),
        .cmd_valid (cmd_valid),
        .cmd_op    (cmd_op),
        .cmd_wdata (cmd_wdata),
        .cmd_ready (cmd_ready),
        .tos       (tos),
        .depth     (depth),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow),
        .err_clr   (err_clr)
    );

    always #5 CLK = ~CLK;

    int n_assert = 0;
    int n_fail   = 0;

    logic [DW-1:0] stk[$];
    bit            m_ovf = 1'b0;
    bit            m_unf = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        logic [DW-1:0] et;
        int sz;
        sz = stk.size();
        et = (sz == 0) ? '0 : stk[sz-1];
        check({tag, ".tos"},       64'(tos),       64'(et));
        check({tag, ".depth"},     64'(depth),     64'(sz));
        check({tag, ".empty"},     64'(empty),     64'(sz == 0));
        check({tag, ".full"},      64'(full),      64'(sz == CAP));
        check({tag, ".overflow"},  64'(overflow),  64'(m_ovf));
        check({tag, ".underflow"}, 64'(underflow), 64'(m_unf));
        check({tag, ".ready"},     64'(cmd_ready), 64'(1));
    endtask

    // Starts and ends on a falling edge.
    task automatic exec(input logic [2:0] op, input logic [DW-1:0] d, input bit clr, input string tag);
        bit            multi;
        int            sz;
        logic [DW-1:0] t;
        multi = 1'b0;
        sz    = stk.size();
        check({tag, ".ready_pre"}, 64'(cmd_ready), 64'(1));
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_wdata = d;
        err_clr   = clr;
        @(negedge CLK);
        cmd_valid = 1'b0;
        err_clr   = 1'b0;
        cmd_op    = OP_NOP;

        if (clr) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end
        case (op)
            OP_PUSH:    if (sz == CAP) m_ovf = 1'b1; else stk.push_back(d);
            OP_POP: begin
                if (sz == 0) m_unf = 1'b1;
                else begin
                    multi = (sz > 1);
                    void'(stk.pop_back());
                end
            end
            OP_REPLACE: if (sz == 0) m_unf = 1'b1; else stk[sz-1] = d;
`ifdef CELL_STACK_SWAP_EN
            OP_SWAP: begin
                if (sz < 2) m_unf = 1'b1;
                else begin
                    t         = stk[sz-1];
                    stk[sz-1] = stk[sz-2];
                    stk[sz-2] = t;
                    multi     = 1'b1;
                end
            end
`endif
            default: ;
        endcase

        check({tag, ".ready_mid"}, 64'(cmd_ready), 64'(!multi));
        if (multi) @(negedge CLK);
        check_state(tag);
    endtask

    initial begin
        int r;
        logic [2:0] op;

        // Reset
        resetn = 1'b0;
        repeat (2) @(negedge CLK);
        check("rst.tos",   64'(tos),       64'(0));
        check("rst.depth", 64'(depth),     64'(0));
        check("rst.ready", 64'(cmd_ready), 64'(1));
        check("rst.ovf",   64'(overflow),  64'(0));
        check("rst.unf",   64'(underflow), 64'(0));
        check("rst.empty", 64'(empty),     64'(1));
        resetn = 1'b1;
        @(negedge CLK);

        // Back-to-back pushes, then pops
        exec(OP_PUSH, 32'h11, 1'b0, "p11");
        exec(OP_PUSH, 32'h22, 1'b0, "p22");
        exec(OP_PUSH, 32'h33, 1'b0, "p33");
        check("p33.tos_lit", 64'(tos), 64'h33);
        exec(OP_POP, '0, 1'b0, "pop1");
        check("pop1.tos_lit", 64'(tos), 64'h22);
        exec(OP_POP, '0, 1'b0, "pop2");
        exec(OP_POP, '0, 1'b0, "pop3");
        check("pop3.empty_lit", 64'(empty), 64'(1));

        // Fill, overflow, clear, drain
        for (int i = 1; i <= 4; i++) exec(OP_PUSH, 32'(i), 1'b0, "fill");
        check("fill.full_lit", 64'(full), 64'(1));
        exec(OP_PUSH, 32'd5, 1'b0, "ovf");
        check("ovf.tos_lit", 64'(tos), 64'd4);
        exec(OP_NOP, '0, 1'b1, "ovfclr");
        for (int i = 4; i >= 1; i--) begin
            check("drain.tos_lit", 64'(tos), 64'(i));
            exec(OP_POP, '0, 1'b0, "drain");
        end

        // Underflow on empty, set beats clear
        exec(OP_POP,     '0,    1'b0, "unf_pop");
        exec(OP_REPLACE, 32'h7, 1'b0, "unf_rep");
        exec(OP_POP,     '0,    1'b1, "unf_setwins");
        check("unf_setwins.lit", 64'(underflow), 64'(1));
        exec(OP_NOP, '0, 1'b1, "unfclr");
        exec(3'd6,   32'h55, 1'b0, "reserved");

`ifdef CELL_STACK_SWAP_EN
        exec(OP_PUSH, 32'hA, 1'b0, "swA");
        exec(OP_PUSH, 32'hB, 1'b0, "swB");
        exec(OP_SWAP, '0,    1'b0, "swap");
        check("swap.tos_lit", 64'(tos), 64'hA);
        exec(OP_POP,  '0,    1'b0, "swpop");
        check("swpop.tos_lit", 64'(tos), 64'hB);
        exec(OP_SWAP, '0,    1'b0, "swap_d1");
        exec(OP_POP,  '0,    1'b1, "swclr");
`else
        exec(OP_PUSH, 32'hA, 1'b0, "nsA");
        exec(OP_SWAP, '0,    1'b0, "swap_off");
        exec(OP_POP,  '0,    1'b0, "nspop");
`endif

        // Reset during POP_WAIT
        exec(OP_PUSH, 32'h1, 1'b0, "rpA");
        exec(OP_PUSH, 32'h2, 1'b0, "rpB");
        exec(OP_PUSH, 32'h3, 1'b0, "rpC");
        cmd_valid = 1'b1;
        cmd_op    = OP_POP;
        @(negedge CLK);
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
        check("rpw.ready_low", 64'(cmd_ready), 64'(0));
        resetn = 1'b0;
        #1;
        check("rpw.depth_async", 64'(depth), 64'(0));
        check("rpw.ready_async", 64'(cmd_ready), 64'(1));
        @(negedge CLK);
        resetn = 1'b1;
        stk.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        check_state("rpw.after");
        exec(OP_PUSH, 32'h5, 1'b0, "rpw.push");

        // Randomised traffic against the model
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 15);
            if (r <= 5)       op = OP_PUSH;
            else if (r <= 10) op = OP_POP;
            else if (r <= 12) op = OP_REPLACE;
            else if (r == 13) op = OP_SWAP;
            else if (r == 14) op = OP_NOP;
            else              op = 3'($urandom_range(5, 7));
            exec(op, $urandom, ($urandom_range(0, 7) == 0), "rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_cell_stack

// File: doc/cell_stack.md
Name: cell_stack

Overview:
- Parametrised hardware data stack, successor to the fixed 256×32 scratch-stack RAM and its stack-pointer logic.
- Top-of-stack (TOS) is held in a register; lower entries live in a synchronous block RAM.
- Push/pop/replace use a valid/ready command handshake, with depth, full/empty and sticky overflow/underflow flags.
- Used by the CPU as the data stack and as the return stack for GOSUB/RET.

Parameters:
- DATA_W, 32, width of one stack cell.
- DEPTH_LOG2, 8, total capacity CAP = 2**DEPTH_LOG2 cells, TOS register included.

Ports:
- CLK  in  1  system clock (16 MHz), all logic on posedge.
- resetn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_op  in  3  0=NOP, 1=PUSH, 2=POP, 3=REPLACE, 4=SWAP (optional), 5-7 reserved.
- cmd_wdata  in  DATA_W  data for PUSH/REPLACE.
- cmd_ready  out  1  command accepted on a cycle where cmd_valid && cmd_ready.
- tos  out  DATA_W  current top of stack (registered).
- depth  out  DEPTH_LOG2+1  number of cells held, 0..CAP.
- empty  out  1  depth==0.
- full  out  1  depth==CAP.
- overflow  out  1  sticky: PUSH while full.
- underflow  out  1  sticky: POP/REPLACE/SWAP with too few cells.
- err_clr  in  1  clears both sticky flags.

Behaviour:
- Reset (async, resetn=0): state=IDLE, depth=0, tos=0, overflow=0, underflow=0, cmd_ready=1. RAM contents are don't-care.
- States: IDLE, POP_WAIT, SWAP_WAIT.
- cmd_ready=1 only in IDLE.
- RAM address is driven combinationally. The RAM output is registered, so read data is valid one cycle after the address.
- RAM index mapping: entry k (0 = bottom) lives at ram[k]. For depth d, TOS is the logical entry d-1 and RAM holds entries 0..d-2.
- PUSH, depth<CAP:
  - if depth>0, write ram[depth-1] <= tos;
  - tos <= cmd_wdata; depth++.
  - Single cycle; stays in IDLE.
- PUSH, depth==CAP: no state change; overflow <= 1.
- POP, depth==1: tos <= 0; depth <= 0. Single cycle.
- POP, depth>1: read ram[depth-2]; go to POP_WAIT. In POP_WAIT: tos <= rdata; depth--; return to IDLE. Latency 2 cycles; cmd_ready low for 1 cycle.
- POP, depth==0: no change; underflow <= 1.
- REPLACE, depth>=1: tos <= cmd_wdata. Single cycle.
- REPLACE, depth==0: no change; underflow <= 1.
- NOP and reserved ops: accepted, no effect, no flag.
- err_clr and an error event in the same cycle: the set wins.
- depth/empty/full update in the same cycle as tos.
- Never a RAM read and write to the same address in the same cycle, so RAM read-during-write behaviour is irrelevant.
- Reset asserted during POP_WAIT/SWAP_WAIT: immediate return to IDLE, depth=0. Any pending read is discarded.
- Arithmetic: depth is unsigned DEPTH_LOG2+1 bits and never wraps; the guards above prevent it. The RAM address is the low DEPTH_LOG2 bits.

Optional Feature:
- Macro CELL_STACK_SWAP_EN.
- Defined: op 4 = SWAP, exchanging TOS and next-on-stack.
  - depth>=2: read ram[depth-2], go to SWAP_WAIT.
  - In SWAP_WAIT: write ram[depth-2] <= tos; tos <= rdata; return to IDLE. Depth unchanged; latency 2 cycles.
  - depth<2: no change; underflow <= 1.
- Undefined: op 4 treated as reserved (accepted NOP). SWAP_WAIT is not synthesised.

Decomposition:
- Package cell_stack_pkg:
  - op-code constants OP_NOP, OP_PUSH, OP_POP, OP_REPLACE, OP_SWAP;
  - state encoding ST_IDLE, ST_POP_WAIT, ST_SWAP_WAIT;
  - CMD_OP_W=3.
- One sub-module, cell_stack_ram: single-port synchronous RAM (clk, addr, din, write_en, registered dout), parametrised DEPTH_LOG2/DATA_W, 2**DEPTH_LOG2 words, infers iCE40 BRAM.

Test Plan:
- Reset, then PUSH 0x11, 0x22, 0x33 back-to-back with cmd_ready held high -> tos=0x33, depth=3, empty=0.
- From that state, POP -> cmd_ready low 1 cycle, then tos=0x22, depth=2. POP twice more -> tos=0, depth=0, empty=1, underflow=0.
- With DEPTH_LOG2=2: PUSH 1..4 -> full=1. PUSH 5 -> overflow=1, tos=4, depth=4. err_clr -> overflow=0. POP×4 returns 4,3,2,1.
- From empty: POP then REPLACE 0x7 -> underflow=1, tos=0, depth=0. err_clr together with a POP on empty -> underflow stays 1.
- With CELL_STACK_SWAP_EN: PUSH 0xA, PUSH 0xB, SWAP -> tos=0xA, then POP -> tos=0xB. SWAP at depth 1 -> underflow=1.
- Deassert resetn for 1 cycle during POP_WAIT at depth 3 -> depth=0, tos=0, cmd_ready=1. Next PUSH 0x5 -> tos=0x5, depth=1.
